xor_checksum: RTL and testbench

Parametrised streaming XOR engine that generalises the 2-input XOR gate to WIDTH-bit words accumulated over a framed stream. It runs in one of two modes. In generate mode it produces the XOR checksum of a frame. In check mode it verifies a frame whose final word is the expected checksum. It sits between a data producer and consumer on valid/ready links and holds one result until the result is accepted.

---
 rtl/xor_checksum_if.sv | 29 ++
 rtl/xor_checksum.sv | 94 +++++++++
 tb/tb_xor_checksum.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/xor_checksum_if.sv
// Valid/ready stream link for the XOR checksum engine: an input word channel
// plus a result channel, and the per-frame mode select.
interface xor_checksum_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 8
);
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [LEN_W-1:0] out_len;
  logic             out_err;

  // Producer/consumer side
  modport master (
    output mode, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_len, out_err
  );

  // Engine side
  modport slave (
    input  mode, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_len, out_err
  );
endinterface

// File: rtl/xor_checksum.sv
// Streaming XOR checksum engine: accumulates a framed word stream and holds
// one result (sum, saturating length, check-mode error) until accepted.
module xor_checksum #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  xor_checksum_if.slave  bus
);

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  state_t           state, state_nx;
  logic             in_ready_c, out_valid_c;
  logic             xfer;
  logic [WIDTH-1:0] acc, acc_nx, sum_q;
  logic [LEN_W-1:0] len, len_inc, len_q;
  logic             mode_q, mode_sel, err_q;

  assign xfer     = bus.in_valid && in_ready_c;
  assign acc_nx   = acc ^ bus.in_data;
  assign len_inc  = (&len) ? len : len + LEN_W'(1);
  // The first word of a frame uses the live mode input; later words use the
  // value captured with that first word.
  assign mode_sel = (len == '0) ? bus.mode : mode_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   state <= ACCUM;
    else if (clr) state <= ACCUM;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ACCUM: if (xfer && bus.in_last) state_nx = DONE;
      DONE:  if (bus.out_ready)       state_nx = ACCUM;
      default: state_nx = ACCUM;
    endcase
  end

  always_comb begin
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    unique case (state)
      ACCUM: in_ready_c  = 1'b1;
      DONE:  out_valid_c = 1'b1;
      default: in_ready_c = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      len    <= '0;
      mode_q <= 1'b0;
      sum_q  <= '0;
      len_q  <= '0;
      err_q  <= 1'b0;
    end else if (clr) begin
      acc   <= '0;
      len   <= '0;
      sum_q <= '0;
      len_q <= '0;
      err_q <= 1'b0;
    end else if (xfer) begin
      if (len == '0) mode_q <= bus.mode;
      if (bus.in_last) begin
        sum_q <= acc_nx;
        len_q <= len_inc;
        err_q <= mode_sel && (acc_nx != '0);
        acc   <= '0;
        len   <= '0;
      end else begin
        acc <= acc_nx;
        len <= len_inc;
      end
    end
  end

  always_comb begin
    bus.in_ready  = in_ready_c;
    bus.out_valid = out_valid_c;
    bus.out_sum   = sum_q;
    bus.out_len   = len_q;
    bus.out_err   = err_q;
  end

endmodule

// File: tb/tb_xor_checksum.sv
// Directed bench for xor_checksum: a wide-counter and a 2-bit-counter
// instance share stimulus; expected results are queued and compared on output.
module tb_xor_checksum;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;

  always #5 clk = ~clk;

  xor_checksum_if #(.WIDTH(8), .LEN_W(8)) ifa ();
  xor_checksum_if #(.WIDTH(8), .LEN_W(2)) ifs ();

  xor_checksum #(.WIDTH(8), .LEN_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(ifa.slave)
  );
  xor_checksum #(.WIDTH(8), .LEN_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(ifs.slave)
  );

  typedef struct {
    logic [7:0] sum;
    logic [7:0] len;
    logic [1:0] len_s;
    logic       err;
  } exp_t;

  exp_t        sb[$];
  int unsigned passed = 0;
  int unsigned total  = 0;

  logic [7:0]  m_acc  = '0;
  int unsigned m_len  = 0;
  logic        m_mode = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic m);
    ifa.in_valid = v; ifa.in_data = d; ifa.in_last = l; ifa.mode = m;
    ifs.in_valid = v; ifs.in_data = d; ifs.in_last = l; ifs.mode = m;
  endtask

  task automatic set_ready(input logic r);
    ifa.out_ready = r;
    ifs.out_ready = r;
  endtask

  task automatic model_clear();
    m_acc = '0;
    m_len = 0;
  endtask

  // Present one word at the next falling edge; it transfers on the following rising edge.
  task automatic xfer(input logic [7:0] d, input logic l, input logic m);
    exp_t e;
    @(negedge clk);
    chk("in_ready_accum", {31'b0, ifa.in_ready}, 32'd1);
    drive(1'b1, d, l, m);
    if (m_len == 0) m_mode = m;
    m_acc = m_acc ^ d;
    m_len++;
    if (l) begin
      e.sum   = m_acc;
      e.len   = (m_len > 255) ? 8'd255 : 8'(m_len);
      e.len_s = (m_len > 3) ? 2'd3 : 2'(m_len);
      e.err   = m_mode && (m_acc != 8'h00);
      sb.push_back(e);
      model_clear();
    end
  endtask

  task automatic idle();
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic expect_result(input string tag);
    exp_t e;
    int unsigned i = 0;
    while (!ifa.out_valid && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_valid"}, {31'b0, ifa.out_valid}, 32'd1);
    chk({tag, "_valid_s"}, {31'b0, ifs.out_valid}, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_sum"},   {24'b0, ifa.out_sum}, {24'b0, e.sum});
      chk({tag, "_len"},   {24'b0, ifa.out_len}, {24'b0, e.len});
      chk({tag, "_err"},   {31'b0, ifa.out_err}, {31'b0, e.err});
      chk({tag, "_sum_s"}, {24'b0, ifs.out_sum}, {24'b0, e.sum});
      chk({tag, "_len_s"}, {30'b0, ifs.out_len}, {30'b0, e.len_s});
      chk({tag, "_err_s"}, {31'b0, ifs.out_err}, {31'b0, e.err});
    end else begin
      chk({tag, "_sb_empty"}, 32'd0, {31'b0, ifa.out_valid});
    end
    @(negedge clk);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_valid"}, {31'b0, ifa.out_valid}, 32'd0);
    chk({tag, "_sum"},   {24'b0, ifa.out_sum},   32'd0);
    chk({tag, "_len"},   {24'b0, ifa.out_len},   32'd0);
    chk({tag, "_err"},   {31'b0, ifa.out_err},   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    set_ready(1'b1);

    // Reset state
    #2;
    chk_cleared("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", {31'b0, ifa.in_ready}, 32'd1);

    // 1: generate mode, 3-word frame
    xfer(8'h12, 1'b0, 1'b0);
    xfer(8'h34, 1'b0, 1'b0);
    xfer(8'h56, 1'b1, 1'b0);
    idle();
    chk("t1_in_ready_done", {31'b0, ifa.in_ready}, 32'd0);
    chk("t1_sum_const", {24'b0, ifa.out_sum}, 32'h70);
    expect_result("t1");
    chk("t1_in_ready_after", {31'b0, ifa.in_ready}, 32'd1);
    chk("t1_valid_after", {31'b0, ifa.out_valid}, 32'd0);

    // 2: check mode, good and bad checksum, mode toggled mid-frame
    xfer(8'h12, 1'b0, 1'b1);
    xfer(8'h34, 1'b0, 1'b0);
    xfer(8'h26, 1'b1, 1'b0);
    idle();
    chk("t2_good_err", {31'b0, ifa.out_err}, 32'd0);
    expect_result("t2_good");
    xfer(8'h12, 1'b0, 1'b1);
    xfer(8'h34, 1'b0, 1'b0);
    xfer(8'h27, 1'b1, 1'b1);
    idle();
    chk("t2_bad_err", {31'b0, ifa.out_err}, 32'd1);
    expect_result("t2_bad");
    xfer(8'h12, 1'b0, 1'b0);
    xfer(8'h34, 1'b0, 1'b1);
    xfer(8'h27, 1'b1, 1'b1);
    idle();
    expect_result("t2_gen");

    // 3: backpressure holds the result and blocks input
    xfer(8'hA5, 1'b1, 1'b0);
    set_ready(1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", {31'b0, ifa.out_valid}, 32'd1);
      chk("t3_hold_sum", {24'b0, ifa.out_sum}, 32'hA5);
      chk("t3_hold_len", {24'b0, ifa.out_len}, 32'd1);
      chk("t3_hold_in_ready", {31'b0, ifa.in_ready}, 32'd0);
      drive(1'b1, 8'hFF, 1'b1, 1'b0);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    set_ready(1'b1);
    expect_result("t3_held");
    xfer(8'h0F, 1'b1, 1'b0);
    idle();
    expect_result("t3_next");

    // 4: length saturation (2-bit counter instance saturates at 3)
    xfer(8'h01, 1'b0, 1'b0);
    xfer(8'h02, 1'b0, 1'b0);
    xfer(8'h04, 1'b0, 1'b0);
    xfer(8'h08, 1'b0, 1'b0);
    xfer(8'h10, 1'b1, 1'b0);
    idle();
    chk("t4_len_sat", {30'b0, ifs.out_len}, 32'd3);
    expect_result("t4");

    // 5: abort mid-frame, with a coinciding input word
    xfer(8'h11, 1'b0, 1'b0);
    xfer(8'h22, 1'b0, 1'b0);
    @(negedge clk);
    clr = 1'b1;
    drive(1'b1, 8'h33, 1'b0, 1'b0);
    @(negedge clk);
    clr = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    model_clear();
    xfer(8'h0F, 1'b1, 1'b0);
    idle();
    expect_result("t5_after_clr");

    // 5b: abort while a result is pending
    xfer(8'h5A, 1'b1, 1'b1);
    idle();
    set_ready(1'b0);
    chk("t5_done_valid", {31'b0, ifa.out_valid}, 32'd1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk_cleared("t5_clr_done");
    chk("t5_clr_in_ready", {31'b0, ifa.in_ready}, 32'd1);
    sb.delete();
    set_ready(1'b1);

    // 6: async reset mid-frame and in DONE, no clock edge needed
    xfer(8'h44, 1'b0, 1'b0);
    idle();
    #2 rst_n = 1'b0;
    #1 chk_cleared("t6_rst_frame");
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    xfer(8'h99, 1'b1, 1'b1);
    idle();
    set_ready(1'b0);
    chk("t6_done_valid", {31'b0, ifa.out_valid}, 32'd1);
    chk("t6_done_err", {31'b0, ifa.out_err}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_cleared("t6_rst_done");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    set_ready(1'b1);
    xfer(8'h3C, 1'b1, 1'b0);
    idle();
    expect_result("t6_after");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
